// File: rtl/multi_breathing_seq.sv
// Breathing-LED engine for NUM_CH outputs. Each output is driven by a PWM whose duty ramps up and back down.
// The engine can step through the enabled channels one at a time, or breathe all enabled channels in lockstep.
module multi_breathing_seq #(
  parameter int NUM_CH   = 4,
  parameter int DEPTH    = 8,
  parameter int PRESCALE = 173,
  parameter int RAMP_W   = 4,
  parameter int CNT_W    = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  input  logic                      stop_i,
  input  logic                      par_mode_i,
  input  logic [RAMP_W-1:0]         ramp_mult_i,
  input  logic [CNT_W-1:0]          breaths_i,
  input  logic [NUM_CH-1:0]         ch_mask_i,
  input  logic [NUM_CH-1:0]         invert_i,
  output logic [NUM_CH-1:0]         led_out_o,
  output logic [$clog2(NUM_CH)-1:0] active_ch_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int AW   = $clog2(NUM_CH);
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [DEPTH-1:0] DUTY_PRE = DEPTH'((2 ** DEPTH) - 2);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t            state_q, state_d;
  logic [PS_W-1:0]   ps_q, ps_d;
  logic [DEPTH-1:0]  pwm_q, pwm_d, duty_q, duty_d;
  logic [RAMP_W-1:0] ramp_q, ramp_d, ramp_cfg_q, ramp_cfg_d;
  logic [CNT_W-1:0]  bcnt_q, bcnt_d, breaths_cfg_q, breaths_cfg_d;
  logic              down_q, down_d, par_q, par_d;
  logic [AW-1:0]     active_q, active_d;
  logic [NUM_CH-1:0] mask_q, mask_d, inv_q, inv_d, led_q, led_d;

  logic              launch, tick, period_end, has_next;
  logic [RAMP_W-1:0] ramp_last;
  logic [CNT_W-1:0]  breaths_eff;
  logic [AW-1:0]     first_ch, next_ch;
  logic [NUM_CH-1:0] sel;

  assign launch      = start_i & ~stop_i & (|ch_mask_i);
  assign tick        = (ps_q == PS_LAST);
  assign period_end  = tick & (&pwm_q);
  assign ramp_last   = (ramp_cfg_q == '0) ? '0 : ramp_cfg_q - 1'b1;
  assign breaths_eff = (breaths_cfg_q == '0) ? CNT_W'(1) : breaths_cfg_q;
  assign sel         = par_q ? mask_q : (NUM_CH'(1) << active_q);

  // Descending scan so the last hit wins: gives the lowest qualifying bit.
  always_comb begin
    first_ch = '0;
    next_ch  = '0;
    has_next = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask_i[i]) first_ch = AW'(i);
      if (mask_q[i] && (i > int'(active_q))) begin
        has_next = 1'b1;
        next_ch  = AW'(i);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ps_d          = ps_q;
    pwm_d         = pwm_q;
    ramp_d        = ramp_q;
    duty_d        = duty_q;
    down_d        = down_q;
    bcnt_d        = bcnt_q;
    active_d      = active_q;
    par_d         = par_q;
    ramp_cfg_d    = ramp_cfg_q;
    breaths_cfg_d = breaths_cfg_q;
    mask_d        = mask_q;
    inv_d         = inv_q;
    led_d         = '0;
    case (state_q)
      IDLE: begin
        if (launch) begin
          state_d       = RUN;
          ps_d          = '0;
          pwm_d         = '0;
          ramp_d        = '0;
          duty_d        = '0;
          down_d        = 1'b0;
          bcnt_d        = '0;
          active_d      = par_mode_i ? '0 : first_ch;
          par_d         = par_mode_i;
          ramp_cfg_d    = ramp_mult_i;
          breaths_cfg_d = breaths_i;
          mask_d        = ch_mask_i;
          inv_d         = invert_i;
          // Duty starts at 0, so the first RUN cycle shows only the polarity.
          led_d         = invert_i;
        end
      end
      RUN: begin
        if (stop_i) begin
          state_d  = IDLE;
          active_d = '0;
        end else begin
          led_d = inv_q ^ (sel & {NUM_CH{pwm_q < duty_q}});
          ps_d  = tick ? '0 : ps_q + 1'b1;
          if (tick) pwm_d = pwm_q + 1'b1;
          if (period_end) begin
            if (ramp_q == ramp_last) begin
              ramp_d = '0;
              if (!down_q) begin
                duty_d = duty_q + 1'b1;
                if (duty_q == DUTY_PRE) down_d = 1'b1;
              end else begin
                duty_d = duty_q - 1'b1;
                if (duty_q == DEPTH'(1)) begin
                  down_d = 1'b0;
                  if (bcnt_q + 1'b1 == breaths_eff) begin
                    bcnt_d = '0;
                    if (!par_q && has_next) begin
                      active_d = next_ch;
                    end else begin
                      state_d  = FINISH;
                      led_d    = '0;
                      active_d = '0;
                    end
                  end else begin
                    bcnt_d = bcnt_q + 1'b1;
                  end
                end
              end
            end else begin
              ramp_d = ramp_q + 1'b1;
            end
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      ps_q          <= '0;
      pwm_q         <= '0;
      ramp_q        <= '0;
      duty_q        <= '0;
      down_q        <= 1'b0;
      bcnt_q        <= '0;
      active_q      <= '0;
      par_q         <= 1'b0;
      ramp_cfg_q    <= '0;
      breaths_cfg_q <= '0;
      mask_q        <= '0;
      inv_q         <= '0;
      led_q         <= '0;
    end else begin
      state_q       <= state_d;
      ps_q          <= ps_d;
      pwm_q         <= pwm_d;
      ramp_q        <= ramp_d;
      duty_q        <= duty_d;
      down_q        <= down_d;
      bcnt_q        <= bcnt_d;
      active_q      <= active_d;
      par_q         <= par_d;
      ramp_cfg_q    <= ramp_cfg_d;
      breaths_cfg_q <= breaths_cfg_d;
      mask_q        <= mask_d;
      inv_q         <= inv_d;
      led_q         <= led_d;
    end
  end

  assign led_out_o   = led_q;
  assign active_ch_o = active_q;
  assign busy_o      = (state_q == RUN);
  assign done_o      = (state_q == FINISH);

endmodule

// File: tb/tb_multi_breathing_seq.sv
// Self-checking bench for multi_breathing_seq at DEPTH=2, PRESCALE=2.
// Per-cycle outputs are compared against a timeline model built from the period, step, breath and segment lengths.
module tb_multi_breathing_seq;
  localparam int NUM_CH   = 4;
  localparam int DEPTH    = 2;
  localparam int PRESCALE = 2;
  localparam int RAMP_W   = 4;
  localparam int CNT_W    = 4;
  localparam int DMAX     = (1 << DEPTH) - 1;
  localparam int PERIOD   = (1 << DEPTH) * PRESCALE;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       parMode = 1'b0;
  logic [3:0] rampMult = '0;
  logic [3:0] breaths = '0;
  logic [3:0] chMask = '0;
  logic [3:0] invert = '0;
  logic [3:0] ledOut;
  logic [1:0] activeCh;
  logic       busy;
  logic       done;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    bit         par;
    logic [3:0] mask;
    logic [3:0] breaths;
    logic [3:0] ramp;
    logic [3:0] inv;
    int         expLen;
    int         expFirst;
  } runVec;

  multi_breathing_seq #(
    .NUM_CH(NUM_CH), .DEPTH(DEPTH), .PRESCALE(PRESCALE), .RAMP_W(RAMP_W), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .stop_i(stop), .par_mode_i(parMode),
    .ramp_mult_i(rampMult), .breaths_i(breaths), .ch_mask_i(chMask), .invert_i(invert),
    .led_out_o(ledOut), .active_ch_o(activeCh), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation hung");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input runVec v, input bit withStop);
    @(negedge clk);
    start    = 1'b1;
    stop     = withStop;
    parMode  = v.par;
    chMask   = v.mask;
    breaths  = v.breaths;
    rampMult = v.ramp;
    invert   = v.inv;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  function automatic int effOne(logic [3:0] x);
    return (x == 4'd0) ? 1 : int'(x);
  endfunction

  function automatic int nthBit(logic [3:0] m, int n);
    int c = 0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        if (c == n) return i;
        c++;
      end
    end
    return 0;
  endfunction

  function automatic int modelLen(runVec v);
    int segs = v.par ? 1 : $countones(v.mask);
    return segs * effOne(v.breaths) * 2 * DMAX * effOne(v.ramp) * PERIOD;
  endfunction

  // Returns {busy, done, led[3:0], active[1:0]} for the k-th cycle after the start edge.
  function automatic logic [7:0] modelAt(runVec v, int k);
    int stepLen   = effOne(v.ramp) * PERIOD;
    int breathLen = 2 * DMAX * stepLen;
    int segLen    = effOne(v.breaths) * breathLen;
    int total     = modelLen(v);
    int act, e, s, duty, pwm;
    logic [3:0] led, sel;
    if (k < 1 || k > total + 1) return 8'h00;
    if (k == total + 1) return 8'b0100_0000;
    act = v.par ? 0 : nthBit(v.mask, (k - 1) / segLen);
    led = v.inv;
    e = k - 2;
    if (e >= 0) begin
      s    = (e % breathLen) / stepLen;
      duty = (s <= DMAX) ? s : 2 * DMAX - s;
      pwm  = (e % PERIOD) / PRESCALE;
      sel  = v.par ? v.mask : 4'(1 << nthBit(v.mask, e / segLen));
      if (pwm < duty) led = led ^ sel;
    end
    return {1'b1, 1'b0, led, 2'(act)};
  endfunction

  task automatic runOne(input runVec v, input string tag);
    int total = modelLen(v);
    int busyCount = 0;
    int doneCount = 0;
    logic [1:0] firstAct = '0;
    logic [7:0] snap;
    applyStimulus(v, 1'b0);
    for (int k = 1; k <= total + 3; k++) begin
      snap = {busy, done, ledOut, (k > total) ? 2'b00 : activeCh};
      checkOutput($sformatf("%s cycle %0d {busy,done,led,ch}", tag, k), 32'(snap), 32'(modelAt(v, k)));
      if (busy) busyCount++;
      if (done) doneCount++;
      if (k == 1) firstAct = activeCh;
      // Config and start churn during the run must have no effect.
      if (k < total) begin
        start    = 1'($urandom);
        parMode  = 1'($urandom);
        chMask   = 4'($urandom);
        breaths  = 4'($urandom);
        rampMult = 4'($urandom);
        invert   = 4'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    checkOutput({tag, " run length"}, 32'(busyCount), 32'(v.expLen));
    checkOutput({tag, " done pulses"}, 32'(doneCount), 32'd1);
    checkOutput({tag, " first channel"}, 32'(firstAct), 32'(v.expFirst));
  endtask

  runVec vecs[7];

  initial begin
    runVec v;
    int hi[6];
    int expHi[6];
    int doneSeen;

    vecs[0] = '{1'b0, 4'b0101, 4'd1, 4'd1, 4'b0000, 96, 0};
    vecs[1] = '{1'b1, 4'b1111, 4'd2, 4'd2, 4'b0000, 192, 0};
    vecs[2] = '{1'b0, 4'b0001, 4'd0, 4'd0, 4'b0000, 48, 0};
    vecs[3] = '{1'b0, 4'b1000, 4'd1, 4'd1, 4'b0000, 48, 3};
    vecs[4] = '{1'b0, 4'b0110, 4'd2, 4'd1, 4'b1001, 192, 1};
    vecs[5] = '{1'b1, 4'b0011, 4'd1, 4'd3, 4'b0100, 144, 0};
    vecs[6] = '{1'b0, 4'b0001, 4'd1, 4'd1, 4'b0010, 48, 0};
    expHi = '{0, 2, 4, 6, 4, 2};

    #1;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset led", 32'(ledOut), 32'd0);
    checkOutput("reset active", 32'(activeCh), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) runOne(vecs[i], $sformatf("vec%0d", i));

    for (int r = 0; r < 5; r++) begin
      v.par      = 1'($urandom_range(0, 1));
      v.mask     = 4'($urandom_range(1, 15));
      v.breaths  = 4'($urandom_range(0, 2));
      v.ramp     = 4'($urandom_range(0, 2));
      v.inv      = 4'($urandom);
      v.expLen   = modelLen(v);
      v.expFirst = v.par ? 0 : nthBit(v.mask, 0);
      runOne(v, $sformatf("rand%0d", r));
    end

    // Duty profile: high clocks per 8-clock PWM period on a lone channel.
    v = '{1'b0, 4'b0001, 4'd1, 4'd1, 4'b0000, 48, 0};
    hi = '{0, 0, 0, 0, 0, 0};
    applyStimulus(v, 1'b0);
    for (int k = 1; k <= 51; k++) begin
      if (k >= 2 && k <= 49 && ledOut[0]) hi[(k - 2) / PERIOD]++;
      @(negedge clk);
    end
    for (int p = 0; p < 6; p++) checkOutput($sformatf("duty period %0d", p), 32'(hi[p]), 32'(expHi[p]));

    // Stop at cycle 20 aborts without a done pulse.
    v = '{1'b0, 4'b0101, 4'd1, 4'd1, 4'b1111, 96, 0};
    applyStimulus(v, 1'b0);
    repeat (19) @(negedge clk);
    checkOutput("stop pre busy", 32'(busy), 32'd1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checkOutput("stop busy", 32'(busy), 32'd0);
    checkOutput("stop led", 32'(ledOut), 32'd0);
    doneSeen = 0;
    for (int k = 0; k < 6; k++) begin
      if (done || busy) doneSeen++;
      @(negedge clk);
    end
    checkOutput("stop no done", 32'(doneSeen), 32'd0);

    v = '{1'b0, 4'b0000, 4'd1, 4'd1, 4'b0000, 0, 0};
    applyStimulus(v, 1'b0);
    checkOutput("start mask0 busy", 32'(busy), 32'd0);
    v.mask = 4'b0101;
    applyStimulus(v, 1'b1);
    checkOutput("start+stop busy", 32'(busy), 32'd0);

    // Asynchronous reset between clock edges.
    v = '{1'b1, 4'b1111, 4'd1, 4'd1, 4'b0101, 48, 0};
    applyStimulus(v, 1'b0);
    repeat (30) @(negedge clk);
    checkOutput("pre-reset busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("async reset busy", 32'(busy), 32'd0);
    checkOutput("async reset led", 32'(ledOut), 32'd0);
    checkOutput("async reset active", 32'(activeCh), 32'd0);
    checkOutput("async reset done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post-reset idle", 32'({busy, done, ledOut}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
